bist_fail_log: RTL and testbench

- Downstream companion to the memory BIST controller.
- Consumes per-read compare results (address, expected data, actual data) during a BIST run.
- Keeps a sticky pass/fail flag and a saturating fail count, and buffers the first DEPTH failing addresses with their XOR syndromes in a FIFO.
- Software or a debug port drains the FIFO through a valid/ready handshake after or during the run.

---
 rtl/bist_pkg.sv | 14 +
 rtl/bist_fail_fifo.sv | 62 ++++++
 rtl/bist_fail_log.sv | 123 ++++++++++++
 tb/tb_bist_fail_log.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST blocks: FSM encoding and default
// address/data widths used by the controller, memory model and fail logger.
package bist_pkg;

  localparam int BIST_ADDR_W = 8;
  localparam int BIST_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/bist_fail_fifo.sv
// Fail-entry FIFO: registered storage with extra-MSB pointers, so full and
// empty can be told apart without a separate occupancy counter.
module bist_fail_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head  = mem_q[rd_ptr_q[AW-1:0]];
  end

  // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bist_fail_log.sv
// BIST fail logger: sticky fail flag, saturating mismatch counter, overflow
// flag and a FIFO of the first failing addresses with their XOR syndromes.
module bist_fail_log
  import bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              done,
  input  logic              cmp_valid,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [DATA_W-1:0] cmp_exp,
  input  logic [DATA_W-1:0] cmp_act,
  output logic              status,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              overflow,
  output logic              busy,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [DATA_W-1:0] log_syn,
  input  logic              log_ready
);

  localparam int ENT_W = ADDR_W + DATA_W;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic             status_q, status_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             mismatch, pop, push, fifo_full, fifo_empty;
  logic [ENT_W-1:0] fifo_head;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: start re-arms from any state and beats done
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (done) state_d = ST_HOLD;
        ST_IDLE: state_d = ST_IDLE;
        ST_HOLD: state_d = ST_HOLD;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q == ST_RUN);
  end

  always_comb begin
    mismatch = (state_q == ST_RUN) && cmp_valid && (cmp_exp != cmp_act) && !start;
    pop      = !fifo_empty && log_ready && !start;
    push     = mismatch && (!fifo_full || pop);
    status_d = status_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (start) begin
      status_d = 1'b0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else if (mismatch) begin
      status_d = 1'b1;
      cnt_d    = sat_inc(cnt_q);
      if (fifo_full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q <= 1'b0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  bist_fail_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .push      (push),
    .push_data ({cmp_addr, cmp_exp ^ cmp_act}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Head is masked while empty so uninitialised storage never reaches the port
  always_comb begin
    status    = status_q;
    fail_cnt  = cnt_q;
    overflow  = ovf_q;
    log_valid = !fifo_empty;
    log_addr  = log_valid ? fifo_head[ENT_W-1:DATA_W] : '0;
    log_syn   = log_valid ? fifo_head[DATA_W-1:0]     : '0;
  end

endmodule

// File: tb/tb_bist_fail_log.sv
// Scoreboard bench for bist_fail_log: stimulus queues expected FIFO entries,
// a monitor pops and compares them whenever the DUT hands one out.
module tb_bist_fail_log;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, done = 1'b0, cmp_valid = 1'b0, log_ready = 1'b0;
  logic [7:0] cmp_addr = '0, cmp_exp = '0, cmp_act = '0;

  logic       status, overflow, busy, log_valid;
  logic [7:0] fail_cnt, log_addr, log_syn;
  logic       s_status, s_overflow, s_busy, s_log_valid;
  logic [1:0] s_fail_cnt;
  logic [7:0] s_log_addr, s_log_syn;

  int vec = 0;
  int err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bist_fail_log #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done), .cmp_valid(cmp_valid),
    .cmp_addr(cmp_addr), .cmp_exp(cmp_exp), .cmp_act(cmp_act),
    .status(status), .fail_cnt(fail_cnt), .overflow(overflow), .busy(busy),
    .log_valid(log_valid), .log_addr(log_addr), .log_syn(log_syn),
    .log_ready(log_ready)
  );

  bist_fail_log #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .done(done), .cmp_valid(cmp_valid),
    .cmp_addr(cmp_addr), .cmp_exp(cmp_exp), .cmp_act(cmp_act),
    .status(s_status), .fail_cnt(s_fail_cnt), .overflow(s_overflow), .busy(s_busy),
    .log_valid(s_log_valid), .log_addr(s_log_addr), .log_syn(s_log_syn),
    .log_ready(log_ready)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vec++;
    if (got !== want) begin
      err++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input logic [7:0] a, input logic [7:0] e, input logic [7:0] act, input bit store);
    cmp_valid = 1'b1;
    cmp_addr  = a;
    cmp_exp   = e;
    cmp_act   = act;
    if (store) exp_q.push_back({a, e ^ act});
    tick();
    cmp_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_q.delete();
    tick();
    start = 1'b0;
  endtask

  // Monitor: an entry leaves the DUT on any edge where valid && ready and no start
  initial begin
    forever begin
      @(negedge clk);
      if (rst && log_valid && log_ready && !start) begin
        vec++;
        if (exp_q.size() == 0) begin
          err++;
          $display("FAIL pop_unexpected got %0h want none", {log_addr, log_syn});
        end else begin
          logic [15:0] want;
          want = exp_q.pop_front();
          if ({log_addr, log_syn} !== want) begin
            err++;
            $display("FAIL pop_entry got %0h want %0h", {log_addr, log_syn}, want);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle: compares are ignored before start
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", status, 0);
    chk("rst_cnt", fail_cnt, 0);
    chk("rst_valid", log_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();
    cmp(8'h01, 8'hAA, 8'h00, 1'b0);
    chk("idle_status", status, 0);
    chk("idle_cnt", fail_cnt, 0);
    chk("idle_valid", log_valid, 0);

    // One mismatch among matches
    do_start();
    chk("run_busy", busy, 1);
    cmp(8'd5, 8'h11, 8'h11, 1'b0);
    cmp(8'd6, 8'h55, 8'h54, 1'b1);
    cmp(8'd7, 8'h22, 8'h22, 1'b0);
    chk("one_status", status, 1);
    chk("one_cnt", fail_cnt, 1);
    chk("one_valid", log_valid, 1);
    chk("one_addr", log_addr, 8'd6);
    chk("one_syn", log_syn, 8'h01);
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    chk("one_drained", log_valid, 0);

    // Six mismatches into a four-entry FIFO
    do_start();
    chk("clr_cnt", fail_cnt, 0);
    for (int i = 0; i < 6; i++) cmp(8'(i), 8'hF0, 8'(i), i < 4);
    chk("ovf_cnt", fail_cnt, 6);
    chk("ovf_flag", overflow, 1);
    chk("sat_cnt", s_fail_cnt, 2'b11);
    log_ready = 1'b1;
    repeat (5) tick();
    log_ready = 1'b0;
    chk("ovf_drained", log_valid, 0);
    chk("ovf_queue", exp_q.size(), 0);

    // Full FIFO: push and pop in the same cycle
    do_start();
    for (int i = 0; i < 4; i++) cmp(8'(i), 8'h0F, 8'hFF, 1'b1);
    log_ready = 1'b1;
    cmp(8'd9, 8'h3C, 8'h00, 1'b1);
    log_ready = 1'b0;
    chk("pp_ovf", overflow, 0);
    chk("pp_cnt", fail_cnt, 5);
    cmp(8'd10, 8'h01, 8'h02, 1'b0);
    chk("pp_still_full", overflow, 1);
    chk("pp_sat", s_fail_cnt, 2'b11);
    log_ready = 1'b1;
    repeat (4) tick();
    log_ready = 1'b0;
    chk("pp_drained", log_valid, 0);
    chk("pp_queue", exp_q.size(), 0);

    // HOLD freezes the log; readout still works
    do_start();
    cmp(8'h20, 8'h00, 8'h80, 1'b1);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("hold_busy", busy, 0);
    cmp(8'h21, 8'h00, 8'hFF, 1'b0);
    chk("hold_cnt", fail_cnt, 1);
    chk("hold_status", status, 1);
    log_ready = 1'b1;
    tick();
    log_ready = 1'b0;
    chk("hold_drained", log_valid, 0);

    // start beats a same-cycle mismatch and pop
    do_start();
    cmp(8'h30, 8'h12, 8'h34, 1'b1);
    chk("pre_valid", log_valid, 1);
    start = 1'b1;
    done = 1'b1;
    log_ready = 1'b1;
    exp_q.delete();
    cmp(8'h31, 8'h12, 8'h35, 1'b0);
    start = 1'b0;
    done = 1'b0;
    log_ready = 1'b0;
    chk("sw_cnt", fail_cnt, 0);
    chk("sw_status", status, 0);
    chk("sw_valid", log_valid, 0);
    chk("sw_busy", busy, 1);
    chk("sw_ovf", overflow, 0);

    // Asynchronous reset mid-run
    cmp(8'h40, 8'h00, 8'h01, 1'b1);
    chk("mid_cnt", fail_cnt, 1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("ar_status", status, 0);
    chk("ar_cnt", fail_cnt, 0);
    chk("ar_valid", log_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", log_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
